// File: rtl/mmu_pkg.sv
// Shared widths, state encoding and small helpers for the MMU front end.
// The TLB and the table-walk stage both use these widths.
package mmu_pkg;

  localparam int MVA_W = 14;
  localparam int OFF_W = 5;
  localparam int VPN_W = 9;
  localparam int PPN_W = 9;
  localparam int CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } tlb_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/mmu_tlb_victim.sv
// Replacement choice for the TLB: lowest-index free entry if one exists,
// otherwise a round-robin pointer that moves only when a valid entry is evicted.
module mmu_tlb_victim
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 8,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic [ENTRIES-1:0] in_valid,
  input  logic               in_fill,
  output logic [IDX_W-1:0]   out_victim
);

  logic [IDX_W-1:0] free_idx;
  logic             any_free;
  logic [IDX_W-1:0] ptr_reg;

  // Scan from the top so the lowest free index is the one left standing.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!in_valid[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

  // ENTRIES is a power of two, so the natural wrap is the modulo.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      ptr_reg <= '0;
    end else if (in_fill && !any_free) begin
      ptr_reg <= ptr_reg + 1'b1;
    end
  end

  assign out_victim = any_free ? free_idx : ptr_reg;

endmodule

// File: rtl/mmu_tlb.sv
// Fully-associative TLB: single-cycle hits, misses handed to the table-walk
// stage and filled on return.
module mmu_tlb
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_req,
  input  logic [MVA_W-1:0] in_mva,
  input  logic             in_flush,
  output logic             out_ready,
  output logic             out_valid,
  output logic [MVA_W-1:0] out_paddr,
  output logic             out_walk_en,
  output logic [MVA_W-1:0] out_walk_mva,
  input  logic             in_walk_done,
  input  logic [MVA_W-1:0] in_walk_paddr,
  output logic [CNT_W-1:0] out_hit_cnt,
  output logic [CNT_W-1:0] out_miss_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  tlb_state_e       state_reg;
  logic [ENTRIES-1:0] valid_reg;
  logic [VPN_W-1:0] vpn_reg [ENTRIES];
  logic [PPN_W-1:0] ppn_reg [ENTRIES];
  logic [MVA_W-1:0] mva_reg;
  logic             flush_pend_reg;

  logic [ENTRIES-1:0] match;
  logic             hit_any;
  logic [PPN_W-1:0] hit_ppn;
  logic             walk_fire;
  logic             do_fill;
  logic [IDX_W-1:0] victim;
  logic             walk_off_unused;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] && (vpn_reg[gi] == in_mva[MVA_W-1:OFF_W]);
    end
  endgenerate

  assign hit_any = |match;

  // At most one entry matches, so OR-ing the selected PPNs is a plain mux.
  always_comb begin
    hit_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (match[i]) begin
        hit_ppn = hit_ppn | ppn_reg[i];
      end
    end
  end

  // A flush seen at any point of the walk suppresses the fill.
  assign walk_fire = (state_reg == ST_WALK) && in_walk_done;
  assign do_fill   = walk_fire && !in_flush && !flush_pend_reg;

  // The page offset of the walk result is never used.
  assign walk_off_unused = ^in_walk_paddr[OFF_W-1:0];

  mmu_tlb_victim #(
    .ENTRIES(ENTRIES)
  ) u_victim (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_valid  (valid_reg),
    .in_fill   (do_fill),
    .out_victim(victim)
  );

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_reg      <= ST_IDLE;
      out_valid      <= 1'b0;
      out_paddr      <= '0;
      mva_reg        <= '0;
      valid_reg      <= '0;
      flush_pend_reg <= 1'b0;
      out_hit_cnt    <= '0;
      out_miss_cnt   <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          flush_pend_reg <= 1'b0;
          if (in_req) begin
            if (hit_any) begin
              out_valid   <= 1'b1;
              out_paddr   <= {hit_ppn, in_mva[OFF_W-1:0]};
              out_hit_cnt <= sat_inc(out_hit_cnt);
            end else begin
              mva_reg      <= in_mva;
              out_miss_cnt <= sat_inc(out_miss_cnt);
              state_reg    <= ST_WALK;
            end
          end
        end
        ST_WALK: begin
          if (in_walk_done) begin
            out_valid      <= 1'b1;
            out_paddr      <= {in_walk_paddr[MVA_W-1:OFF_W], mva_reg[OFF_W-1:0]};
            flush_pend_reg <= 1'b0;
            state_reg      <= ST_IDLE;
          end else if (in_flush) begin
            flush_pend_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      // Same-cycle lookups above still see the pre-flush valid bits.
      if (in_flush) begin
        valid_reg <= '0;
      end else if (do_fill) begin
        valid_reg[victim] <= 1'b1;
      end
    end
  end

  // Tag/data storage needs no reset: valid_reg gates every use.
  always_ff @(posedge in_clk) begin
    if (do_fill && !in_rst) begin
      vpn_reg[victim] <= mva_reg[MVA_W-1:OFF_W];
      ppn_reg[victim] <= in_walk_paddr[MVA_W-1:OFF_W];
    end
  end

  assign out_ready    = (state_reg == ST_IDLE);
  assign out_walk_en  = (state_reg == ST_WALK);
  assign out_walk_mva = mva_reg;

endmodule

// File: tb/tb_mmu_tlb.sv
// Directed plus randomized bench for mmu_tlb, checked against a simple
// array-based model of the TLB contents, victim choice and counters.
module tb_mmu_tlb;
  import mmu_pkg::*;

  localparam int ENTRIES = 8;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b1;
  logic        in_req = 1'b0;
  logic [13:0] in_mva = '0;
  logic        in_flush = 1'b0;
  logic        in_walk_done = 1'b0;
  logic [13:0] in_walk_paddr = '0;
  logic        out_ready;
  logic        out_valid;
  logic [13:0] out_paddr;
  logic        out_walk_en;
  logic [13:0] out_walk_mva;
  logic [15:0] out_hit_cnt;
  logic [15:0] out_miss_cnt;

  mmu_tlb #(.ENTRIES(ENTRIES)) dut (
    .in_clk       (in_clk),
    .in_rst       (in_rst),
    .in_req       (in_req),
    .in_mva       (in_mva),
    .in_flush     (in_flush),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_paddr    (out_paddr),
    .out_walk_en  (out_walk_en),
    .out_walk_mva (out_walk_mva),
    .in_walk_done (in_walk_done),
    .in_walk_paddr(in_walk_paddr),
    .out_hit_cnt  (out_hit_cnt),
    .out_miss_cnt (out_miss_cnt)
  );

  always #5 in_clk = ~in_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: what each entry holds, the replacement pointer, counts.
  bit m_valid[ENTRIES];
  int m_vpn[ENTRIES];
  int m_ppn[ENTRIES];
  int m_ptr = 0;
  int m_hits = 0;
  int m_misses = 0;
  int pt[512];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  function automatic int sat(input int x);
    return (x > 65535) ? 65535 : x;
  endfunction

  function automatic int m_lookup(input int vpn);
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_vpn[i] == vpn) return i;
    return -1;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic void m_fill(input int vpn, input int ppn);
    int v;
    v = -1;
    for (int i = 0; i < ENTRIES; i++)
      if (!m_valid[i] && v < 0) v = i;
    if (v < 0) begin
      v = m_ptr;
      m_ptr = (m_ptr + 1) % ENTRIES;
    end
    m_valid[v] = 1'b1;
    m_vpn[v] = vpn;
    m_ppn[v] = ppn;
  endfunction

  function automatic void m_reset();
    m_clear();
    m_ptr = 0;
    m_hits = 0;
    m_misses = 0;
  endfunction

  // One translation; hit or miss is decided by the model, the DUT must agree.
  task automatic do_req(input logic [13:0] mva, input int delay, input bit flush_walk,
                        input bit flush_accept);
    int vpn;
    int idx;
    int ppn;
    bit flushed;
    logic [8:0] p9;
    logic [13:0] exp_pa;
    vpn = int'(mva[13:5]);
    idx = m_lookup(vpn);
    flushed = 1'b0;
    check("ready_before_req", out_ready, 1);
    in_req = 1'b1;
    in_mva = mva;
    in_flush = flush_accept;
    #1;
    check("single_match", $onehot0(dut.match), 1);
    tick();
    in_req = 1'b0;
    in_flush = 1'b0;
    if (flush_accept) m_clear();
    if (idx >= 0) begin
      m_hits++;
      p9 = m_ppn[idx][8:0];
      exp_pa = {p9, mva[4:0]};
      $display("req mva=%h hit  paddr=%h", mva, out_paddr);
      check("hit_valid", out_valid, 1);
      check("hit_paddr", out_paddr, exp_pa);
      check("hit_no_walk", out_walk_en, 0);
      check("hit_ready", out_ready, 1);
      check("hit_cnt", out_hit_cnt, sat(m_hits));
    end else begin
      m_misses++;
      check("miss_walk_en", out_walk_en, 1);
      check("miss_walk_mva", out_walk_mva, mva);
      check("miss_not_ready", out_ready, 0);
      check("miss_no_valid", out_valid, 0);
      check("miss_cnt", out_miss_cnt, sat(m_misses));
      for (int c = 0; c < delay; c++) begin
        if (flush_walk && c == 0) in_flush = 1'b1;
        tick();
        if (in_flush) begin
          flushed = 1'b1;
          m_clear();
        end
        in_flush = 1'b0;
        check("walk_held", out_walk_en, 1);
        check("walk_mva_stable", out_walk_mva, mva);
      end
      if (flush_walk && delay == 0) begin
        in_flush = 1'b1;
        flushed = 1'b1;
        m_clear();
      end
      ppn = pt[vpn];
      p9 = ppn[8:0];
      in_walk_done = 1'b1;
      in_walk_paddr = {p9, 5'($urandom)};
      tick();
      in_walk_done = 1'b0;
      in_flush = 1'b0;
      if (!flushed) m_fill(vpn, ppn);
      exp_pa = {p9, mva[4:0]};
      $display("req mva=%h miss paddr=%h flushed=%0d", mva, out_paddr, flushed);
      check("walk_valid", out_valid, 1);
      check("walk_paddr", out_paddr, exp_pa);
      check("walk_en_drop", out_walk_en, 0);
      check("walk_ready", out_ready, 1);
      check("walk_miss_cnt", out_miss_cnt, sat(m_misses));
    end
  endtask

  task automatic idle_flush();
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    m_clear();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) pt[i] = int'($urandom_range(0, 511));
    pt[9] = 'h1D0;
    m_reset();

    repeat (3) tick();
    in_rst = 1'b0;
    check("rst_ready", out_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_paddr", out_paddr, 0);
    check("rst_walk_en", out_walk_en, 0);
    check("rst_walk_mva", out_walk_mva, 0);
    check("rst_hit_cnt", out_hit_cnt, 0);
    check("rst_miss_cnt", out_miss_cnt, 0);

    // First miss and the hit that follows it.
    do_req(14'h0123, 3, 1'b0, 1'b0);
    check("tp_miss_paddr", out_paddr, 14'h3A03);
    check("tp_miss_cnt", out_miss_cnt, 1);
    do_req(14'h013F, 0, 1'b0, 1'b0);
    check("tp_hit_paddr", out_paddr, 14'h3A1F);
    check("tp_hit_cnt", out_hit_cnt, 1);

    // Walk result arriving while idle must be ignored.
    in_walk_done = 1'b1;
    in_walk_paddr = 14'h1234;
    tick();
    in_walk_done = 1'b0;
    check("stray_done_valid", out_valid, 0);
    check("stray_done_ready", out_ready, 1);

    // Fill all entries, then exercise round-robin eviction.
    idle_flush();
    for (int v = 0; v < 8; v++) do_req({9'(v), 5'(v)}, v % 3, 1'b0, 1'b0);
    do_req({9'd8, 5'd1}, 1, 1'b0, 1'b0);
    do_req({9'd0, 5'd2}, 0, 1'b0, 1'b0);
    do_req({9'd1, 5'd3}, 2, 1'b0, 1'b0);
    do_req({9'd2, 5'd4}, 0, 1'b0, 1'b0);

    // Flush during a walk: result returned but not filled.
    idle_flush();
    for (int v = 0; v < 4; v++) do_req({9'(v), 5'd0}, 0, 1'b0, 1'b0);
    do_req({9'd5, 5'd7}, 2, 1'b1, 1'b0);
    do_req({9'd5, 5'd8}, 1, 1'b0, 1'b0);
    for (int v = 0; v < 4; v++) do_req({9'(v), 5'd9}, 0, 1'b0, 1'b0);

    // Randomized traffic over a VPN set slightly larger than the TLB.
    for (int n = 0; n < 400; n++) begin
      do_req({9'($urandom_range(0, 11)), 5'($urandom)}, int'($urandom_range(0, 3)),
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 7) == 0) tick();
    end

    // Reset in the middle of a walk.
    idle_flush();
    do_req({9'd20, 5'd1}, 0, 1'b0, 1'b0);
    in_req = 1'b1;
    in_mva = {9'd21, 5'd2};
    tick();
    in_req = 1'b0;
    check("pre_rst_walk_en", out_walk_en, 1);
    repeat (2) tick();
    in_rst = 1'b1;
    tick();
    in_rst = 1'b0;
    m_reset();
    check("mid_rst_walk_en", out_walk_en, 0);
    check("mid_rst_ready", out_ready, 1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_paddr", out_paddr, 0);
    check("mid_rst_walk_mva", out_walk_mva, 0);
    check("mid_rst_hit_cnt", out_hit_cnt, 0);
    check("mid_rst_miss_cnt", out_miss_cnt, 0);
    in_walk_done = 1'b1;
    in_walk_paddr = 14'h3FFF;
    tick();
    in_walk_done = 1'b0;
    check("late_done_valid", out_valid, 0);
    check("late_done_walk_en", out_walk_en, 0);
    $display("reset during walk: valid=%0d walk_en=%0d", out_valid, out_walk_en);
    do_req({9'd20, 5'd3}, 1, 1'b0, 1'b0);

    // Back-to-back hits until the hit counter saturates.
    do_req({9'd3, 5'd0}, 0, 1'b0, 1'b0);
    in_req = 1'b1;
    in_mva = {9'd3, 5'd17};
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (i == 100) begin
        check("b2b_valid", out_valid, 1);
        check("b2b_ready", out_ready, 1);
        check("b2b_hit_cnt", out_hit_cnt, sat(m_hits + i + 1));
      end
    end
    in_req = 1'b0;
    m_hits += 70000;
    $display("saturation: hit_cnt=%h miss_cnt=%h", out_hit_cnt, out_miss_cnt);
    check("sat_hit_cnt", out_hit_cnt, 16'hFFFF);
    check("sat_miss_cnt", out_miss_cnt, sat(m_misses));
    tick();
    check("sat_valid_drop", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmu_tlb.md
# mmu_tlb

Fully-associative translation lookaside buffer at the front of the MMU. It accepts 14-bit modified virtual addresses (MVAs) from the core side and returns a 14-bit physical address. On a hit it answers in one cycle. On a miss it drives the two-level table-walk stage, holds the request until the walk completes, fills an entry and returns the result.

## Interface
- `ENTRIES`, default 8: number of TLB entries; power of two, 2..32.
- `in_clk`  input  1: single clock, all state on rising edge.
- `in_rst`  input  1: synchronous, active-high reset.
- `in_req`  input  1: translation request; accepted when `in_req & out_ready`.
- `in_mva`  input  14: MVA; `[13:5]` VPN, `[4:0]` page offset.
- `in_flush`  input  1: invalidate all entries.
- `out_ready`  output  1: high when able to accept a request (state IDLE).
- `out_valid`  output  1: one-cycle pulse; `out_paddr` is valid.
- `out_paddr`  output  14: translated address `{PPN[8:0], offset[4:0]}`.
- `out_walk_en`  output  1: walk request to the table-walk stage; level-held.
- `out_walk_mva`  output  14: MVA to walk; stable while `out_walk_en` is high.
- `in_walk_done`  input  1: walk result valid; single-cycle pulse.
- `in_walk_paddr`  input  14: walked physical address; only `[13:5]` is used.
- `out_hit_cnt`  output  16: saturating hit counter.
- `out_miss_cnt`  output  16: saturating miss counter.

## Operation
- Entry contents: `valid`, `vpn[8:0]`, `ppn[8:0]`. No permission or domain bits.
- States:
  - IDLE: `out_ready` = 1.
  - WALK: `out_ready` = 0, `out_walk_en` = 1.
- IDLE, request accepted: `in_mva[13:5]` is compared against every valid entry combinationally.
  - Hit: register `{ppn, in_mva[4:0]}` into `out_paddr`, pulse `out_valid` next cycle, increment the hit count, stay in IDLE.
  - Miss: latch the MVA, increment the miss count, go to WALK.
- WALK: hold `out_walk_en` = 1 and `out_walk_mva` = latched MVA. When `in_walk_done` = 1:
  - fill the victim entry with vpn = latched `[13:5]` and ppn = `in_walk_paddr[13:5]`;
  - drive `out_paddr` = `{in_walk_paddr[13:5], latched[4:0]}` and pulse `out_valid` next cycle;
  - go to IDLE.
- Victim selection: the lowest-index invalid entry. If all entries are valid, use the round-robin pointer, which then increments modulo `ENTRIES`. The pointer advances only on fills that evict a valid entry.
- Multiple matching entries are impossible by construction, since a fill only occurs after a miss. The bench asserts this.
- `in_flush` clears every `valid` bit. Counters and the pointer are unaffected.
  - Flush in IDLE together with `in_req`: the lookup uses pre-flush contents. The flush takes effect next cycle.
  - Flush during WALK: entries are invalidated. The pending walk result is still returned but not filled.
- `in_walk_done` outside WALK is ignored.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: `out_ready` = 1 (IDLE), `out_valid` = 0, `out_paddr` = 0, `out_walk_en` = 0, `out_walk_mva` = 0, both counters 0, all `valid` = 0, pointer = 0.
- Hit latency: accept at cycle N, `out_valid` at N+1. `out_ready` stays high, giving one translation per cycle for back-to-back hits.
- Miss timing:
  - accept at N;
  - `out_walk_en` rises at N+1;
  - `in_walk_done` may arrive as early as N+1;
  - `in_walk_done` sampled at M gives `out_valid` at M+1 with `out_walk_en` = 0, and `out_ready` = 1 at M+1.
- The filled entry is visible to lookups from cycle M+1. A same-VPN request accepted at M+1 hits.
- Reset has priority over all inputs. Reset during WALK drops `out_walk_en` the next cycle, and no `out_valid` is produced. A late `in_walk_done` after reset is ignored.
- One outstanding walk at a time. There is no timeout; WALK waits indefinitely.

## Structure
- Shared package `mmu_pkg`:
  - constants `MVA_W=14`, `OFF_W=5`, `VPN_W=9`, `PPN_W=9`;
  - state encoding `ST_IDLE=1'b0`, `ST_WALK=1'b1`;
  - counter width `CNT_W=16`.
  - The table-walk stage imports the same widths.
- Sub-module `mmu_tlb_victim`: priority encoder for the first invalid entry, plus the round-robin pointer register. Outputs the victim index.

## Test plan
- After reset, request MVA 14'h0123 → WALK with `out_walk_en`=1 and `out_walk_mva`=14'h0123. Return walk paddr 14'h3A00 after 3 cycles → `out_valid` with `out_paddr`=14'h3A03, miss_cnt=1.
- Same VPN, MVA 14'h013F, on the cycle after `out_valid` → hit with `out_paddr`=14'h3A1F one cycle later, no walk, hit_cnt=1.
- Fill 8 distinct VPNs 0..7, then VPN 8 → evicts entry 0. A request for VPN 0 then misses and evicts entry 1.
- `in_flush` during WALK for VPN 5 → result still returned. A subsequent VPN 5 request misses again, and all prior VPNs miss.
- Assert `in_rst` 2 cycles into a walk, then pulse `in_walk_done` → no `out_valid`, all outputs at reset values, next request misses.
- 70000 back-to-back hits → hit_cnt saturates at 16'hFFFF, miss_cnt unchanged.
